// File: rtl/md_sequencer_pkg.sv
// Shared constants for the EX-stage multiply/divide sequencer:
// shared-ALU opcodes, MD_OP encodings and FSM state encodings.
package md_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0010
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_UMUL = 2'b00,
    MD_SMUL = 2'b01,
    MD_UDIV = 2'b10,
    MD_RSVD = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_MUL,
    S_FIX1,
    S_FIX2,
    S_DIV,
    S_DONE
  } state_e;

endpackage

// File: rtl/md_sequencer.sv
// Multi-cycle UMUL/SMUL/UDIV sequencer that borrows the shared EX-stage ALU:
// shift-and-add multiply with signed fix-up, restoring divide with overflow check.
module md_sequencer
  import md_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            START,
  input  logic [1:0]      MD_OP,
  input  logic [XLEN-1:0] OPA,
  input  logic [XLEN-1:0] OPB,
  input  logic [XLEN-1:0] Y_IN,
  input  logic            FLUSH,
  input  logic [XLEN-1:0] ALU_OUT,
  input  logic            C_EX,
  output logic            ALU_SEL,
  output logic [XLEN-1:0] SEQ_A,
  output logic [XLEN-1:0] SEQ_B,
  output logic [3:0]      SEQ_OP,
  output logic            STALL,
  output logic            DONE,
  output logic [XLEN-1:0] RES_LO,
  output logic [XLEN-1:0] RES_HI,
  output logic            Y_WE,
  output logic            DZ
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   res_lo_q, res_lo_d;
  logic [XLEN-1:0]   res_hi_q, res_hi_d;
  logic [1:0]        op_q, op_d;
  logic              dz_q, dz_d;

  logic              op_valid;
  logic              accept;
  logic              last_iter;
  logic              qbit;
  logic [XLEN-1:0]   div_shift;

  // hi/lo double as {HI,LO} for multiply and {R,Q} for divide; m holds M or D.
  assign op_valid  = (MD_OP != MD_RSVD);
  assign accept    = (state_q == S_IDLE) && START && op_valid && !FLUSH;
  assign last_iter = (cnt_q == CNT_W'(ITER - 1));
  assign div_shift = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  assign qbit      = hi_q[XLEN-1] | C_EX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      b_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      op_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      b_q      <= b_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      op_q     <= op_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && FLUSH) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (MD_OP == MD_UDIV) state_d = (OPB == '0) ? S_DONE : S_CHK;
            else                  state_d = S_MUL;
          end
        end
        S_CHK:   state_d = C_EX ? S_DONE : S_DIV;
        S_MUL:   if (last_iter) state_d = (op_q == MD_SMUL) ? S_FIX1 : S_DONE;
        S_FIX1:  state_d = S_FIX2;
        S_FIX2:  state_d = S_DONE;
        S_DIV:   if (last_iter) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    b_d      = b_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    op_d     = op_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = MD_OP;
          cnt_d = '0;
          dz_d  = 1'b0;
          b_d   = OPB;
          if (MD_OP == MD_UDIV) begin
            hi_d = Y_IN;
            lo_d = OPA;
            m_d  = OPB;
            if (OPB == '0) begin
              dz_d = 1'b1;
              hi_d = '0;
              lo_d = '0;
            end
          end else begin
            hi_d = '0;
            lo_d = OPB;
            m_d  = OPA;
          end
        end
      end
      S_CHK: begin
        if (C_EX) begin
          hi_d = '0;
          lo_d = '1;
        end
      end
      S_MUL: begin
        hi_d  = {C_EX, ALU_OUT[XLEN-1:1]};
        lo_d  = {ALU_OUT[0], lo_q[XLEN-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIX1: if (m_q[XLEN-1]) hi_d = ALU_OUT;
      S_FIX2: if (b_q[XLEN-1]) hi_d = ALU_OUT;
      S_DIV: begin
        hi_d  = qbit ? ALU_OUT : div_shift;
        lo_d  = {lo_q[XLEN-2:0], qbit};
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
    // Results are captured only on the way into DONE, so a flush leaves them intact.
    if (state_d == S_DONE) begin
      res_hi_d = hi_d;
      res_lo_d = lo_d;
    end
  end

  always_comb begin
    ALU_SEL = 1'b0;
    STALL   = 1'b0;
    SEQ_A   = '0;
    SEQ_B   = '0;
    SEQ_OP  = ALU_ADD;
    case (state_q)
      S_IDLE: STALL = START && op_valid && !rst;
      S_CHK: begin
        ALU_SEL = 1'b1;
        STALL   = 1'b1;
        SEQ_A   = hi_q;
        SEQ_B   = m_q;
        SEQ_OP  = ALU_SUB;
      end
      S_MUL: begin
        ALU_SEL = 1'b1;
        STALL   = 1'b1;
        SEQ_A   = hi_q;
        SEQ_B   = lo_q[0] ? m_q : '0;
        SEQ_OP  = ALU_ADD;
      end
      S_FIX1: begin
        ALU_SEL = 1'b1;
        STALL   = 1'b1;
        SEQ_A   = hi_q;
        SEQ_B   = b_q;
        SEQ_OP  = ALU_SUB;
      end
      S_FIX2: begin
        ALU_SEL = 1'b1;
        STALL   = 1'b1;
        SEQ_A   = hi_q;
        SEQ_B   = m_q;
        SEQ_OP  = ALU_SUB;
      end
      S_DIV: begin
        ALU_SEL = 1'b1;
        STALL   = 1'b1;
        SEQ_A   = div_shift;
        SEQ_B   = m_q;
        SEQ_OP  = ALU_SUB;
      end
      default: ;
    endcase
  end

  assign DONE   = (state_q == S_DONE);
  assign Y_WE   = DONE && (op_q != MD_UDIV);
  assign DZ     = DONE && dz_q;
  assign RES_LO = res_lo_q;
  assign RES_HI = res_hi_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: models the shared ALU, drives a vector
// table plus random ops through a scoreboard, and covers flush/reset/held-START cases.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        START = 1'b0;
  logic        FLUSH = 1'b0;
  logic [1:0]  MD_OP = 2'b00;
  logic [31:0] OPA = '0;
  logic [31:0] OPB = '0;
  logic [31:0] Y_IN = '0;
  logic [31:0] ALU_OUT;
  logic        C_EX;
  logic        ALU_SEL, STALL, DONE, Y_WE, DZ;
  logic [31:0] SEQ_A, SEQ_B, RES_LO, RES_HI;
  logic [3:0]  SEQ_OP;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        y_we;
    logic        dz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    exp_t        exp;
  } vec_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  md_sequencer dut (
    .clk(clk), .rst(rst), .START(START), .MD_OP(MD_OP), .OPA(OPA), .OPB(OPB),
    .Y_IN(Y_IN), .FLUSH(FLUSH), .ALU_OUT(ALU_OUT), .C_EX(C_EX),
    .ALU_SEL(ALU_SEL), .SEQ_A(SEQ_A), .SEQ_B(SEQ_B), .SEQ_OP(SEQ_OP),
    .STALL(STALL), .DONE(DONE), .RES_LO(RES_LO), .RES_HI(RES_HI),
    .Y_WE(Y_WE), .DZ(DZ)
  );

  always #5 clk = ~clk;

  // Shared ALU: garbage when the sequencer does not own it, so stray use shows up.
  always_comb begin
    ALU_OUT = 32'hDEADBEEF;
    C_EX    = 1'b1;
    if (ALU_SEL) begin
      if (SEQ_OP == 4'b0000) begin
        {C_EX, ALU_OUT} = {1'b0, SEQ_A} + {1'b0, SEQ_B};
      end else if (SEQ_OP == 4'b0010) begin
        ALU_OUT = SEQ_A - SEQ_B;
        C_EX    = (SEQ_A >= SEQ_B);
      end else begin
        ALU_OUT = 32'hBAD0BAD0;
        C_EX    = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t refModel(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] y);
    exp_t               e;
    logic [63:0]        p;
    logic [63:0]        dvd;
    logic signed [63:0] sp;
    e = '{hi: 32'h0, lo: 32'h0, y_we: 1'b0, dz: 1'b0, lat: 0};
    case (op)
      2'b00: begin
        p = {32'h0, a} * {32'h0, b};
        e.hi = p[63:32]; e.lo = p[31:0]; e.y_we = 1'b1; e.lat = 33;
      end
      2'b01: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.hi = sp[63:32]; e.lo = sp[31:0]; e.y_we = 1'b1; e.lat = 35;
      end
      default: begin
        if (b == 32'h0) begin
          e.dz = 1'b1; e.lat = 1;
        end else if (y >= b) begin
          e.lo = 32'hFFFFFFFF; e.lat = 2;
        end else begin
          dvd = {y, a};
          p = dvd / {32'h0, b};
          e.lo = p[31:0];
          p = dvd % {32'h0, b};
          e.hi = p[31:0];
          e.lat = 34;
        end
      end
    endcase
    return e;
  endfunction

  task automatic doReset();
    rst = 1'b1; START = 1'b0; FLUSH = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_lo = '0; last_hi = '0;
  endtask

  // Drives START at a negedge (cycle 0) and checks the combinational stall request.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] y, input exp_t e, input bit expect_done);
    @(negedge clk);
    MD_OP = op; OPA = a; OPB = b; Y_IN = y; START = 1'b1;
    if (expect_done) sb_q.push_back(e);
    #1;
    checkOutput("stall_at_start", 64'(STALL), 64'(op != 2'b11));
  endtask

  task automatic waitDone(input bit hold);
    int   k;
    int   busy_bad;
    exp_t e;
    k = 0;
    busy_bad = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (DONE) begin
        k = i;
        break;
      end
      if (!(STALL && ALU_SEL)) busy_bad++;
      if (!hold) START = 1'b0;
    end
    if (k == 0) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL done_timeout: got no DONE in 80 cycles, expected DONE");
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      doReset();
      return;
    end
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL unexpected_done: got DONE, expected none");
      return;
    end
    e = sb_q.pop_front();
    checkOutput("res_lo", 64'(RES_LO), 64'(e.lo));
    checkOutput("res_hi", 64'(RES_HI), 64'(e.hi));
    checkOutput("y_we", 64'(Y_WE), 64'(e.y_we));
    checkOutput("dz", 64'(DZ), 64'(e.dz));
    checkOutput("latency", 64'(k), 64'(e.lat));
    checkOutput("busy_stall_alusel_bad_cycles", 64'(busy_bad), 64'(0));
    checkOutput("done_cycle_stall_alusel", 64'({STALL, ALU_SEL}), 64'(0));
    last_lo = e.lo; last_hi = e.hi;
    @(negedge clk);
    checkOutput("after_done_done_alusel", 64'({DONE, ALU_SEL}), 64'(0));
    checkOutput("res_held", {RES_HI, RES_LO}, {e.hi, e.lo});
    START = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[14];
    exp_t        none;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b, r_y;
    int          bad;

    none = '{hi: 32'h0, lo: 32'h0, y_we: 1'b0, dz: 1'b0, lat: 0};
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        '{32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0, 33}};
    vecs[1]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h0,        '{32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 1'b0, 35}};
    vecs[2]  = '{2'b10, 32'd100,      32'd7,        32'h0,        '{32'd2,        32'd14,       1'b0, 1'b0, 34}};
    vecs[3]  = '{2'b10, 32'h0,        32'd3,        32'd5,        '{32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 2}};
    vecs[4]  = '{2'b10, 32'd123,      32'h0,        32'd9,        '{32'h0,        32'h0,        1'b0, 1'b1, 1}};
    vecs[5]  = '{2'b00, 32'h00010000, 32'h00010000, 32'h0,        '{32'h1,        32'h0,        1'b1, 1'b0, 33}};
    vecs[6]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h0,        '{32'h40000000, 32'h0,        1'b1, 1'b0, 35}};
    vecs[7]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        '{32'h0,        32'h1,        1'b1, 1'b0, 35}};
    vecs[8]  = '{2'b01, 32'd7,        32'hFFFFFFFB, 32'h0,        '{32'hFFFFFFFF, 32'hFFFFFFDD, 1'b1, 1'b0, 35}};
    vecs[9]  = '{2'b10, 32'h0,        32'd2,        32'd1,        '{32'h0,        32'h80000000, 1'b0, 1'b0, 34}};
    vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0, 34}};
    vecs[11] = '{2'b10, 32'd7,        32'd7,        32'h0,        '{32'h0,        32'h1,        1'b0, 1'b0, 34}};
    vecs[12] = '{2'b10, 32'd55,       32'd3,        32'd3,        '{32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 2}};
    vecs[13] = '{2'b00, 32'h0,        32'hFFFFFFFF, 32'h0,        '{32'h0,        32'h0,        1'b1, 1'b0, 33}};

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("reset_res", {RES_HI, RES_LO}, 64'h0);
    checkOutput("reset_flags", 64'({DONE, Y_WE, DZ, ALU_SEL, STALL}), 64'(0));
    checkOutput("reset_seq", {SEQ_A, SEQ_B}, 64'h0);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].exp, 1'b1);
      waitDone(1'b0);
    end

    $display("[TB] random operations");
    for (int i = 0; i < 9; i++) begin
      r_op = 2'(i % 3);
      r_a  = $urandom;
      r_b  = $urandom;
      r_y  = (r_b != 32'h0 && i < 8) ? ($urandom % r_b) : $urandom;
      applyStimulus(r_op, r_a, r_b, r_y, refModel(r_op, r_a, r_b, r_y), 1'b1);
      waitDone(1'b0);
    end

    $display("[TB] reserved opcode");
    applyStimulus(2'b11, 32'd1, 32'd2, 32'd3, none, 1'b0);
    bad = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (DONE || ALU_SEL || STALL) bad++;
    end
    checkOutput("reserved_stays_idle", 64'(bad), 64'(0));
    START = 1'b0;

    $display("[TB] flush mid-multiply");
    applyStimulus(2'b00, 32'h12345678, 32'h9ABCDEF0, 32'h0, none, 1'b0);
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (DONE || !ALU_SEL) bad++;
      START = 1'b0;
      if (k == 10) FLUSH = 1'b1;
    end
    @(negedge clk);
    FLUSH = 1'b0;
    checkOutput("flush_busy_before", 64'(bad), 64'(0));
    checkOutput("flush_idle_flags", 64'({DONE, ALU_SEL, STALL}), 64'(0));
    checkOutput("flush_res_held", {RES_HI, RES_LO}, {last_hi, last_lo});
    applyStimulus(2'b00, 32'd3, 32'd5, 32'h0, '{32'h0, 32'd15, 1'b1, 1'b0, 33}, 1'b1);
    waitDone(1'b0);

    $display("[TB] async reset mid-divide with START held");
    applyStimulus(2'b10, 32'd100, 32'd7, 32'h0, none, 1'b0);
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (!(ALU_SEL && STALL) || DONE) bad++;
    end
    checkOutput("div_busy_before_reset", 64'(bad), 64'(0));
    #2;
    rst = 1'b1;
    START = 1'b0;
    #1;
    checkOutput("midrst_res", {RES_HI, RES_LO}, 64'h0);
    checkOutput("midrst_flags", 64'({DONE, Y_WE, DZ, ALU_SEL, STALL}), 64'(0));
    checkOutput("midrst_seq", {SEQ_A, SEQ_B}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    last_lo = '0; last_hi = '0;

    $display("[TB] START held through busy and DONE");
    applyStimulus(2'b10, 32'd1000, 32'd33, 32'h0, '{32'd10, 32'd30, 1'b0, 1'b0, 34}, 1'b1);
    waitDone(1'b1);
    @(negedge clk);
    checkOutput("post_hold_idle", 64'({DONE, ALU_SEL, STALL}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
